// File: rtl/raysk_pkg.sv
// raysk_pkg: definitions shared by the trace_dispatch frame scheduler and its
// per-core trace_slot instances.
//   RGB_W / COORD_W : pixel color and coordinate widths
//   slot_state_e    : per-core slot lifecycle (FREE -> RUN -> HELD -> FREE)
//   frame_state_e   : frame-level scheduler state (IDLE -> RUN -> DRAIN -> IDLE)
//   pixel_t         : one output pixel {x, y, rgb}
//   coord_next()    : raster-counter increment that wraps to 0 after 'last'
package raysk_pkg;

    localparam int RGB_W   = 24;
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_RUN  = 2'd1,
        SLOT_HELD = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        FRM_IDLE  = 2'd0,
        FRM_RUN   = 2'd1,
        FRM_DRAIN = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RGB_W-1:0]   rgb;
    } pixel_t;

    function automatic logic [COORD_W-1:0] coord_next(
        input logic [COORD_W-1:0] value,
        input logic [COORD_W-1:0] last
    );
        logic [COORD_W-1:0] result;
        if (value == last) begin
            result = {COORD_W{1'b0}};
        end else begin
            result = value + {{(COORD_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/trace_slot.sv
// trace_slot: bookkeeping for one trace_path core (ap_ctrl_hs).
// Ports:
//   clk, ap_rst          clock, asynchronous active-high reset
//   dispatch             load disp_x/disp_y and start the core (only while FREE)
//   disp_x, disp_y       raster coordinate being dispatched
//   core_ready/core_done core handshake inputs
//   core_ret             core result {R,G,B}
//   retire               result consumed by the output register (only while HELD)
//   is_free, is_held     slot state flags for the scheduler
//   core_start           ap_start to the core
//   core_x, core_y       coordinate of the pixel owned by this slot; they stay
//                        constant from dispatch until the next dispatch, so they
//                        double as the captured coordinate of the held result
//   res_rgb              captured core result
module trace_slot
    import raysk_pkg::*;
(
    input  logic               clk,
    input  logic               ap_rst,
    input  logic               dispatch,
    input  logic [COORD_W-1:0] disp_x,
    input  logic [COORD_W-1:0] disp_y,
    input  logic               core_ready,
    input  logic               core_done,
    input  logic [RGB_W-1:0]   core_ret,
    input  logic               retire,
    output logic               is_free,
    output logic               is_held,
    output logic               core_start,
    output logic [COORD_W-1:0] core_x,
    output logic [COORD_W-1:0] core_y,
    output logic [RGB_W-1:0]   res_rgb
);

    slot_state_e        state_r;
    slot_state_e        state_next_s;
    logic               start_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [RGB_W-1:0]   rgb_r;

    // Slot lifecycle next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SLOT_FREE: begin
                if (dispatch) begin
                    state_next_s = SLOT_RUN;
                end else begin
                    state_next_s = SLOT_FREE;
                end
            end
            SLOT_RUN: begin
                if (core_done) begin
                    state_next_s = SLOT_HELD;
                end else begin
                    state_next_s = SLOT_RUN;
                end
            end
            SLOT_HELD: begin
                if (retire) begin
                    state_next_s = SLOT_FREE;
                end else begin
                    state_next_s = SLOT_HELD;
                end
            end
            default: begin
                state_next_s = SLOT_FREE;
            end
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= SLOT_FREE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // ap_start handshake and coordinate latch: start holds until ready is sampled.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            start_r <= 1'b0;
            x_r     <= {COORD_W{1'b0}};
            y_r     <= {COORD_W{1'b0}};
        end else if ((state_r == SLOT_FREE) && dispatch) begin
            start_r <= 1'b1;
            x_r     <= disp_x;
            y_r     <= disp_y;
        end else if (start_r && core_ready) begin
            start_r <= 1'b0;
        end
    end

    // Result capture on ap_done; the output stage only ever reads this register.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            rgb_r <= {RGB_W{1'b0}};
        end else if ((state_r == SLOT_RUN) && core_done) begin
            rgb_r <= core_ret;
        end
    end

    assign is_free    = (state_r == SLOT_FREE);
    assign is_held    = (state_r == SLOT_HELD);
    assign core_start = start_r;
    assign core_x     = x_r;
    assign core_y     = y_r;
    assign res_rgb    = rgb_r;

endmodule

// File: rtl/trace_dispatch.sv
// trace_dispatch: renders one frame by scattering raster pixels round-robin over
// NUM_CORES trace_path cores and gathering results back in raster order.
// Ports:
//   clk, ap_rst              clock, asynchronous active-high reset
//   frame_start              one-cycle frame request (ignored while busy)
//   busy, frame_done         frame in progress / one-cycle completion pulse
//   core_start/ready/done    per-core ap_ctrl_hs handshake
//   core_x, core_y           per-core coordinate (8 bits per core)
//   core_ret                 per-core result {R,G,B} (24 bits per core)
//   pix_valid, pix_ready     output pixel stream handshake
//   pix_x, pix_y, pix_rgb    output pixel
// Dispatch pointer d and retire pointer r visit slots in the same order, so
// results leave in raster order whatever order the cores finish in.
module trace_dispatch
    import raysk_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int X_MAX     = 160,
    parameter int Y_MAX     = 120
) (
    input  logic                       clk,
    input  logic                       ap_rst,
    input  logic                       frame_start,
    output logic                       busy,
    output logic                       frame_done,
    output logic [NUM_CORES-1:0]       core_start,
    input  logic [NUM_CORES-1:0]       core_ready,
    input  logic [NUM_CORES-1:0]       core_done,
    output logic [8*NUM_CORES-1:0]     core_x,
    output logic [8*NUM_CORES-1:0]     core_y,
    input  logic [24*NUM_CORES-1:0]    core_ret,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [7:0]                 pix_x,
    output logic [7:0]                 pix_y,
    output logic [23:0]                pix_rgb
);

    localparam int                 PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_CORES - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_MAX - 1);

    // Round-robin pointer step that wraps at NUM_CORES-1 (not a power of two).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] result;
        if (p == PTR_LAST) begin
            result = {PTR_W{1'b0}};
        end else begin
            result = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    frame_state_e       state_r;
    frame_state_e       state_next_s;
    logic [COORD_W-1:0] x_cnt_r;
    logic [COORD_W-1:0] y_cnt_r;
    logic [PTR_W-1:0]   d_ptr_r;
    logic [PTR_W-1:0]   r_ptr_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               pix_valid_r;
    pixel_t             pix_r;

    logic                 start_ok_s;
    logic                 disp_go_s;
    logic [PTR_W-1:0]     disp_idx_s;
    logic [COORD_W-1:0]   disp_x_s;
    logic [COORD_W-1:0]   disp_y_s;
    logic                 last_pix_s;
    logic                 retire_go_s;
    logic                 drain_exit_s;
    logic [NUM_CORES-1:0] disp_vec_s;
    logic [NUM_CORES-1:0] ret_vec_s;
    logic [NUM_CORES-1:0] slot_free_s;
    logic [NUM_CORES-1:0] slot_held_s;
    logic [COORD_W-1:0]   slot_x_s   [NUM_CORES];
    logic [COORD_W-1:0]   slot_y_s   [NUM_CORES];
    logic [RGB_W-1:0]     slot_rgb_s [NUM_CORES];

    // Dispatch / retire decisions. An accepted frame_start dispatches pixel
    // (0,0) to slot 0 in the same cycle, as if counters and pointers were cleared.
    always_comb begin
        start_ok_s = (state_r == FRM_IDLE) && frame_start;
        if (start_ok_s) begin
            disp_idx_s = {PTR_W{1'b0}};
            disp_x_s   = {COORD_W{1'b0}};
            disp_y_s   = {COORD_W{1'b0}};
            disp_go_s  = 1'b1;
        end else begin
            disp_idx_s = d_ptr_r;
            disp_x_s   = x_cnt_r;
            disp_y_s   = y_cnt_r;
            disp_go_s  = (state_r == FRM_RUN) && slot_free_s[d_ptr_r];
        end
        last_pix_s   = disp_go_s && (disp_x_s == X_LAST) && (disp_y_s == Y_LAST);
        // The output register may load when empty or when it transfers this cycle.
        retire_go_s  = slot_held_s[r_ptr_r] && (!pix_valid_r || pix_ready);
        drain_exit_s = (state_r == FRM_DRAIN) && (&slot_free_s) && !pix_valid_r;
        disp_vec_s   = {NUM_CORES{1'b0}};
        ret_vec_s    = {NUM_CORES{1'b0}};
        for (int i = 0; i < NUM_CORES; i++) begin
            disp_vec_s[i] = disp_go_s && (disp_idx_s == PTR_W'(i));
            ret_vec_s[i]  = retire_go_s && (r_ptr_r == PTR_W'(i));
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FRM_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = last_pix_s ? FRM_DRAIN : FRM_RUN;
                end else begin
                    state_next_s = FRM_IDLE;
                end
            end
            FRM_RUN: begin
                if (last_pix_s) begin
                    state_next_s = FRM_DRAIN;
                end else begin
                    state_next_s = FRM_RUN;
                end
            end
            FRM_DRAIN: begin
                if (drain_exit_s) begin
                    state_next_s = FRM_IDLE;
                end else begin
                    state_next_s = FRM_DRAIN;
                end
            end
            default: begin
                state_next_s = FRM_IDLE;
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= FRM_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Raster counters and dispatch pointer advance on every dispatch.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            x_cnt_r <= {COORD_W{1'b0}};
            y_cnt_r <= {COORD_W{1'b0}};
            d_ptr_r <= {PTR_W{1'b0}};
        end else if (disp_go_s) begin
            x_cnt_r <= coord_next(disp_x_s, X_LAST);
            y_cnt_r <= (disp_x_s == X_LAST) ? coord_next(disp_y_s, Y_LAST) : disp_y_s;
            d_ptr_r <= ptr_next(disp_idx_s);
        end
    end

    // Retire pointer: cleared on frame accept, advanced on every retire.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_ptr_r <= {PTR_W{1'b0}};
        end else if (start_ok_s) begin
            r_ptr_r <= {PTR_W{1'b0}};
        end else if (retire_go_s) begin
            r_ptr_r <= ptr_next(r_ptr_r);
        end
    end

    // Output register: reload without a bubble, otherwise hold until accepted.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            pix_valid_r <= 1'b0;
            pix_r       <= '0;
        end else if (retire_go_s) begin
            pix_valid_r <= 1'b1;
            pix_r       <= {slot_x_s[r_ptr_r], slot_y_s[r_ptr_r], slot_rgb_s[r_ptr_r]};
        end else if (pix_ready) begin
            pix_valid_r <= 1'b0;
        end
    end

    // Frame status: busy spans accept..completion, frame_done marks completion.
    always_ff @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= drain_exit_s;
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (drain_exit_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        trace_slot u_slot (
            .clk        (clk),
            .ap_rst     (ap_rst),
            .dispatch   (disp_vec_s[g]),
            .disp_x     (disp_x_s),
            .disp_y     (disp_y_s),
            .core_ready (core_ready[g]),
            .core_done  (core_done[g]),
            .core_ret   (core_ret[RGB_W*g +: RGB_W]),
            .retire     (ret_vec_s[g]),
            .is_free    (slot_free_s[g]),
            .is_held    (slot_held_s[g]),
            .core_start (core_start[g]),
            .core_x     (slot_x_s[g]),
            .core_y     (slot_y_s[g]),
            .res_rgb    (slot_rgb_s[g])
        );
        assign core_x[COORD_W*g +: COORD_W] = slot_x_s[g];
        assign core_y[COORD_W*g +: COORD_W] = slot_y_s[g];
    end

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign pix_valid  = pix_valid_r;
    assign pix_x      = pix_r.x;
    assign pix_y      = pix_r.y;
    assign pix_rgb    = pix_r.rgb;

endmodule

// File: tb/tb_trace_dispatch.sv
// Bench for trace_dispatch with NUM_CORES=2, X_MAX=4, Y_MAX=2. Cores are
// modelled as ap_ctrl_hs blocks returning {x, y, 8'h5A}; the expected pixel
// stream is simply the raster walk y-major, x-minor.
module tb_trace_dispatch;

    localparam int NC   = 2;
    localparam int XM   = 4;
    localparam int YM   = 2;
    localparam int NPIX = XM * YM;

    logic            clk = 1'b0;
    logic            ap_rst;
    logic            frame_start;
    logic            busy;
    logic            frame_done;
    logic [NC-1:0]   core_start;
    logic [NC-1:0]   core_ready;
    logic [NC-1:0]   core_done;
    logic [8*NC-1:0] core_x;
    logic [8*NC-1:0] core_y;
    logic [24*NC-1:0] core_ret;
    logic            pix_valid;
    logic            pix_ready;
    logic [7:0]      pix_x;
    logic [7:0]      pix_y;
    logic [23:0]     pix_rgb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trace_dispatch #(.NUM_CORES(NC), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk        (clk),
        .ap_rst     (ap_rst),
        .frame_start(frame_start),
        .busy       (busy),
        .frame_done (frame_done),
        .core_start (core_start),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_ret   (core_ret),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb)
    );

    // ---------------- core model (ap_ctrl_hs, reset by ap_rst) ----------------
    int         lat_cfg [NC];
    int         rdy_cfg [NC];
    bit         rand_lat = 1'b0;
    logic       m_busy  [NC];
    int         m_k     [NC];
    int         m_lat   [NC];
    logic [7:0] m_x     [NC];
    logic [7:0] m_y     [NC];

    // Each core accepts start, raises ready rdy_cfg cycles later and done
    // m_lat cycles after start.
    always @(posedge clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NC; i++) begin
                m_busy[i] <= 1'b0;
                m_k[i]    <= 0;
                m_lat[i]  <= 0;
                m_x[i]    <= 8'd0;
                m_y[i]    <= 8'd0;
                core_ready[i] <= 1'b0;
                core_done[i]  <= 1'b0;
                core_ret[24*i +: 24] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (m_busy[i]) begin
                    m_k[i]        <= m_k[i] + 1;
                    core_ready[i] <= ((m_k[i] + 1) == rdy_cfg[i]);
                    if ((m_k[i] + 1) == m_lat[i]) begin
                        core_done[i] <= 1'b1;
                        core_ret[24*i +: 24] <= {m_x[i], m_y[i], 8'h5A};
                        m_busy[i] <= 1'b0;
                    end else begin
                        core_done[i] <= 1'b0;
                        core_ret[24*i +: 24] <= 24'd0;
                    end
                end else if (core_start[i]) begin
                    m_busy[i] <= 1'b1;
                    m_k[i]    <= 1;
                    m_x[i]    <= core_x[8*i +: 8];
                    m_y[i]    <= core_y[8*i +: 8];
                    m_lat[i]  <= rand_lat ? int'($urandom_range(9, 2)) : lat_cfg[i];
                    core_ready[i] <= (rdy_cfg[i] == 1);
                    core_done[i]  <= 1'b0;
                    core_ret[24*i +: 24] <= 24'd0;
                end else begin
                    core_ready[i] <= 1'b0;
                    core_done[i]  <= 1'b0;
                    core_ret[24*i +: 24] <= 24'd0;
                end
            end
        end
    end

    // ---------------- reference: raster walk ----------------
    function automatic logic [39:0] exp_pix(input int n);
        logic [7:0] ex;
        logic [7:0] ey;
        ex = 8'(n % XM);
        ey = 8'(n / XM);
        return {ex, ey, ex, ey, 8'h5A};
    endfunction

    // ---------------- frame runner (records observations only) ----------------
    bit  rand_ready     = 1'b0;
    int  stall_at       = -1;
    int  stall_len      = 0;
    int  extra_start_at = -1;

    logic [39:0] obs_q [$];
    int done_cnt, stable_err, xy_err, start_late, first_s0, first_s1;
    int s0_len, busy_after, first_xfer, s1_second, post;
    bit timed_out, busy_at1;

    task automatic run_frame(input int budget);
        bit          prev_stall;
        bit          prev_s1;
        bit          s0_ended;
        int          s1_rises;
        logic [39:0] prev_pix;
        obs_q.delete();
        done_cnt = 0; stable_err = 0; xy_err = 0; start_late = 0;
        first_s0 = -1; first_s1 = -1; s0_len = 0; busy_after = 0;
        first_xfer = -1; s1_second = -1; post = -1; timed_out = 1'b0; busy_at1 = 1'b0;
        prev_stall = 1'b0; prev_s1 = 1'b0; s0_ended = 1'b0; s1_rises = 0; prev_pix = 40'd0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            frame_start = (c == 0) || (c == extra_start_at);
            if (rand_ready) begin
                pix_ready = ($urandom_range(3, 0) != 0);
            end else begin
                pix_ready = !((stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len));
            end
            if (c == 1) busy_at1 = busy;
            if (core_start[0] && first_s0 < 0) first_s0 = c;
            if (core_start[1] && first_s1 < 0) first_s1 = c;
            if (!s0_ended) begin
                if (core_start[0]) s0_len++;
                else if (s0_len > 0) s0_ended = 1'b1;
            end
            if (core_start[1] && !prev_s1) begin
                s1_rises++;
                if (s1_rises == 2) s1_second = c;
            end
            prev_s1 = core_start[1];
            if (prev_stall && ((pix_valid !== 1'b1) || ({pix_x, pix_y, pix_rgb} !== prev_pix)))
                stable_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = {pix_x, pix_y, pix_rgb};
            if (pix_valid && pix_ready) begin
                obs_q.push_back({pix_x, pix_y, pix_rgb});
                if (first_xfer < 0) first_xfer = c;
            end
            for (int i = 0; i < NC; i++) begin
                if ((m_busy[i] || core_done[i]) &&
                    ((core_x[8*i +: 8] !== m_x[i]) || (core_y[8*i +: 8] !== m_y[i])))
                    xy_err++;
            end
            if ((stall_len > 0) && (c >= stall_at + 10) && (c < stall_at + stall_len) && (|core_start))
                start_late++;
            if (post >= 0) begin
                if (busy) busy_after++;
                post++;
                if (post > 30) break;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (post < 0) post = 0;
            end
        end
        if (post <= 30) timed_out = 1'b1;
        frame_start = 1'b0;
        pix_ready   = 1'b1;
    endtask

    task automatic set_defaults();
        rand_lat = 1'b0; rand_ready = 1'b0;
        stall_at = -1; stall_len = 0; extra_start_at = -1;
        for (int i = 0; i < NC; i++) begin
            lat_cfg[i] = 5;
            rdy_cfg[i] = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ap_rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b1;
        set_defaults();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, frame_done, pix_valid} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, frame_done, pix_valid});
        else n_pass++;
        n_checks++;
        if ({core_start, core_x, core_y} !== '0) $display("FAIL reset_core got %h want 0", {core_start, core_x, core_y});
        else n_pass++;
        n_checks++;
        if ({pix_x, pix_y, pix_rgb} !== 40'd0) $display("FAIL reset_pix got %h want 0", {pix_x, pix_y, pix_rgb});
        else n_pass++;
        ap_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        set_defaults();
        run_frame(2000);
        n_checks++;
        if (timed_out) $display("FAIL basic_timeout got timeout want frame_done");
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL basic_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_pix(i)) $display("FAIL basic_pix%0d got %h want %h", i, obs_q[i], exp_pix(i));
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1) $display("FAIL basic_done got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (busy_after !== 0) $display("FAIL basic_busy_after got %0d want 0", busy_after);
        else n_pass++;
        n_checks++;
        if (busy_at1 !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_at1);
        else n_pass++;
        n_checks++;
        if ((first_s0 !== 1) || (first_s1 !== 2)) $display("FAIL dispatch_latency got %0d/%0d want 1/2", first_s0, first_s1);
        else n_pass++;
        n_checks++;
        if (xy_err !== 0) $display("FAIL basic_xy_stable got %0d want 0", xy_err);
        else n_pass++;
    endtask

    task automatic test_out_of_order();
        set_defaults();
        lat_cfg[0] = 9;
        lat_cfg[1] = 2;
        run_frame(2000);
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL ooo_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_pix(i)) $display("FAIL ooo_pix%0d got %h want %h", i, obs_q[i], exp_pix(i));
            else n_pass++;
        end
        // slot 1 can only be restarted after it is freed, i.e. after pixel 0 left
        n_checks++;
        if ((s1_second < 0) || (first_xfer < 0) || (s1_second <= first_xfer))
            $display("FAIL ooo_held got restart %0d want after %0d", s1_second, first_xfer);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL ooo_done got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_stall();
        set_defaults();
        stall_at  = 10;
        stall_len = 20;
        run_frame(2000);
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL stall_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_pix(i)) $display("FAIL stall_pix%0d got %h want %h", i, obs_q[i], exp_pix(i));
            else n_pass++;
        end
        n_checks++;
        if (stable_err !== 0) $display("FAIL stall_stable got %0d changes want 0", stable_err);
        else n_pass++;
        n_checks++;
        if (start_late !== 0) $display("FAIL stall_no_dispatch got %0d starts want 0", start_late);
        else n_pass++;
    endtask

    task automatic test_ready_delay();
        set_defaults();
        rdy_cfg[0] = 3; rdy_cfg[1] = 3;
        lat_cfg[0] = 6; lat_cfg[1] = 6;
        run_frame(2000);
        // start high from dispatch through the cycle ready is sampled: 3 + 1
        n_checks++;
        if (s0_len !== 4) $display("FAIL rdy_start_len got %0d want 4", s0_len);
        else n_pass++;
        n_checks++;
        if (xy_err !== 0) $display("FAIL rdy_xy_stable got %0d want 0", xy_err);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL rdy_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_pix(i)) $display("FAIL rdy_pix%0d got %h want %h", i, obs_q[i], exp_pix(i));
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        set_defaults();
        extra_start_at = 5;
        run_frame(2000);
        n_checks++;
        if (done_cnt !== 1) $display("FAIL busy_start_frames got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL busy_start_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        n_checks++;
        if (busy_after !== 0) $display("FAIL busy_start_idle got %0d want 0", busy_after);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int xfers;
        bit hit;
        set_defaults();
        xfers = 0;
        hit   = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            frame_start = (c == 0);
            pix_ready   = 1'b1;
            if (xfers == 3) begin
                hit = 1'b1;
                break;
            end
            if (pix_valid && pix_ready) xfers++;
        end
        frame_start = 1'b0;
        n_checks++;
        if (!hit) $display("FAIL rst_mid_reach got %0d pixels want 3", xfers);
        else n_pass++;
        ap_rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, frame_done, pix_valid, core_start} !== '0)
            $display("FAIL rst_mid_flags got %b want 0", {busy, frame_done, pix_valid, core_start});
        else n_pass++;
        n_checks++;
        if ({core_x, core_y, pix_x, pix_y, pix_rgb} !== '0)
            $display("FAIL rst_mid_data got %h want 0", {core_x, core_y, pix_x, pix_y, pix_rgb});
        else n_pass++;
        repeat (2) @(negedge clk);
        ap_rst = 1'b0;
        run_frame(2000);
        n_checks++;
        if (obs_q.size() !== NPIX) $display("FAIL rst_mid_count got %0d want %0d", obs_q.size(), NPIX);
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_pix(i)) $display("FAIL rst_mid_pix%0d got %h want %h", i, obs_q[i], exp_pix(i));
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1) $display("FAIL rst_mid_done got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        set_defaults();
        rand_lat   = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            run_frame(3000);
            n_checks++;
            if (obs_q.size() !== NPIX) $display("FAIL rand%0d_count got %0d want %0d", f, obs_q.size(), NPIX);
            else n_pass++;
            for (int i = 0; i < obs_q.size() && i < NPIX; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_pix(i)) $display("FAIL rand%0d_pix%0d got %h want %h", f, i, obs_q[i], exp_pix(i));
                else n_pass++;
            end
            n_checks++;
            if ((done_cnt !== 1) || (stable_err !== 0) || (xy_err !== 0))
                $display("FAIL rand%0d_misc got done=%0d stab=%0d xy=%0d want 1/0/0", f, done_cnt, stable_err, xy_err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_stall();
        test_ready_delay();
        test_start_while_busy();
        test_reset_midframe();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
